// File: rtl/pipe_adder.sv
// Pipelined carry-chain adder/subtractor: each stage adds one CHUNK-bit slice and
// hands its carry, the partial sum and the untouched upper operand bits to the next stage.
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic             stall_s;
  logic             advance_s;

  logic [WIDTH-1:0] a_r     [STAGES];
  logic [WIDTH-1:0] b_r     [STAGES];
  logic [WIDTH-1:0] sum_r   [STAGES];
  logic             carry_r [STAGES];
  logic             valid_r [STAGES];
  logic             ovf_r;

  logic [WIDTH-1:0] src_a_s   [STAGES];
  logic [WIDTH-1:0] src_b_s   [STAGES];
  logic [WIDTH-1:0] src_sum_s [STAGES];
  logic             src_c_s   [STAGES];
  logic             src_v_s   [STAGES];
  logic [WIDTH-1:0] nxt_sum_s [STAGES];
  logic [CHUNK:0]   chunk_s   [STAGES];
  logic             msb_cin_s;
  logic             ovf_nxt_s;

  // The whole pipeline freezes only when a finished result is refused downstream.
  assign stall_s   = valid_r[LAST] & ~out_ready;
  assign advance_s = ~stall_s;
  assign in_ready  = advance_s;

  // Stage sources, per-stage chunk adders and the signed-overflow term of the top chunk.
  always_comb begin
    src_a_s[0]   = a;
    src_b_s[0]   = sub ? ~b : b;
    src_c_s[0]   = sub ? 1'b1 : c_in;
    src_v_s[0]   = in_valid;
    src_sum_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_a_s[k]   = a_r[k-1];
      src_b_s[k]   = b_r[k-1];
      src_c_s[k]   = carry_r[k-1];
      src_v_s[k]   = valid_r[k-1];
      src_sum_s[k] = sum_r[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      chunk_s[k] = {1'b0, src_a_s[k][k*CHUNK +: CHUNK]}
                 + {1'b0, src_b_s[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, src_c_s[k]};
      nxt_sum_s[k] = src_sum_s[k];
      nxt_sum_s[k][k*CHUNK +: CHUNK] = chunk_s[k][CHUNK-1:0];
    end
    // The carry entering the MSB is recovered from the MSB sum bit and its two addends.
    msb_cin_s = src_a_s[LAST][WIDTH-1] ^ src_b_s[LAST][WIDTH-1] ^ nxt_sum_s[LAST][WIDTH-1];
    ovf_nxt_s = msb_cin_s ^ chunk_s[LAST][CHUNK];
  end

  // Stage registers: cleared asynchronously, advanced together, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_r[k] <= 1'b0;
        carry_r[k] <= 1'b0;
        sum_r[k]   <= '0;
        a_r[k]     <= '0;
        b_r[k]     <= '0;
      end
      ovf_r <= 1'b0;
    end else if (advance_s) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_r[k] <= src_v_s[k];
        carry_r[k] <= chunk_s[k][CHUNK];
        sum_r[k]   <= nxt_sum_s[k];
        a_r[k]     <= src_a_s[k];
        b_r[k]     <= src_b_s[k];
      end
      ovf_r <= ovf_nxt_s;
    end
  end

  assign out_valid = valid_r[LAST];
  assign s         = sum_r[LAST];
  assign c_out     = carry_r[LAST];
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed corner cases, stall and reset scenarios,
// and a long random valid/ready run scored against an arithmetic reference queue.
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        c_in;
  logic        sub;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  wire         in_ready;
  wire         out_valid;
  wire         c_out;
  wire         ovf;
  wire  [15:0] s;
  wire         in_ready1;
  wire         out_valid1;
  wire         c_out1;
  wire         ovf1;
  wire  [15:0] s1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [17:0] exp_q[$];

  bit          acc;
  bit          cons;
  bit          stl;
  bit          rdy;
  logic [17:0] got;
  logic [17:0] e;
  int          lat;
  int          sent;
  int          got_n;
  logic [15:0] ev;
  bit          exp_v;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out), .ovf(ovf)
  );

  pipe_adder #(.WIDTH(16), .CHUNK(16)) u_one (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid1), .out_ready(out_ready),
    .s(s1), .c_out(c_out1), .ovf(ovf1)
  );

  // Reference: {ovf, c_out, s} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    int          sx;
    int          sy;
    int          sr;
    logic [16:0] full;
    logic [15:0] d;
    logic        ov;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      sr = sx - sy;
      d  = x - y;
      full = {(x >= y), d};
    end else begin
      sr = sx + sy + (ci ? 32'sd1 : 32'sd0);
      full = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, full};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock: note handshakes seen before the edge, log accepted operands, step the clock.
  task automatic tick(output bit t_acc, output bit t_cons, output logic [17:0] t_got,
                      output bit t_stl, output bit t_rdy);
    #1;
    t_acc  = rst_n && in_valid && in_ready;
    t_cons = rst_n && out_valid && out_ready;
    t_stl  = out_valid && !out_ready;
    t_rdy  = in_ready;
    t_got  = {ovf, c_out, s};
    if (t_acc) exp_q.push_back(model(a, b, c_in, sub));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; a = 16'h1234; b = 16'h1111; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick(acc, cons, got, stl, rdy);
    n_checks++;
    if ({out_valid, ovf, c_out, s} !== 19'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", {out_valid, ovf, c_out, s}, 19'h0);
    end
    n_checks++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready, in_ready1);
    end
    n_checks++;
    if ({out_valid1, ovf1, c_out1, s1} !== 19'h0) begin
      n_fail++; $display("FAIL reset_one_stage: got %h expected %h", {out_valid1, ovf1, c_out1, s1}, 19'h0);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_directed();
    in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    tick(acc, cons, got, stl, rdy);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid1, ovf1, c_out1, s1} !== {1'b1, 1'b0, 1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL one_stage_latency1: got %h expected %h",
                         {out_valid1, ovf1, c_out1, s1}, {1'b1, 1'b0, 1'b1, 16'h0000});
    end
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick(acc, cons, got, stl, rdy);
      lat++;
    end
    n_checks++;
    if (lat != 4) begin
      n_fail++; $display("FAIL latency: got %0d expected 4", lat);
    end
    n_checks++;
    if ({ovf, c_out, s} !== {1'b0, 1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL ffff_plus_1: got %h expected %h", {ovf, c_out, s}, {1'b0, 1'b1, 16'h0000});
    end
    in_valid = 1'b1; a = 16'h7FFF; b = 16'h0001; c_in = 1'b0; sub = 1'b0;
    tick(acc, cons, got, stl, rdy);
    a = 16'h0005; b = 16'h0007; c_in = 1'b1; sub = 1'b1;
    tick(acc, cons, got, stl, rdy);
    in_valid = 1'b0;
    tick(acc, cons, got, stl, rdy);
    tick(acc, cons, got, stl, rdy);
    n_checks++;
    if ({out_valid, ovf, c_out, s} !== {1'b1, 1'b1, 1'b0, 16'h8000}) begin
      n_fail++; $display("FAIL signed_overflow: got %h expected %h",
                         {out_valid, ovf, c_out, s}, {1'b1, 1'b1, 1'b0, 16'h8000});
    end
    tick(acc, cons, got, stl, rdy);
    n_checks++;
    if ({out_valid, ovf, c_out, s} !== {1'b1, 1'b0, 1'b0, 16'hFFFE}) begin
      n_fail++; $display("FAIL sub_borrow: got %h expected %h",
                         {out_valid, ovf, c_out, s}, {1'b1, 1'b0, 1'b0, 16'hFFFE});
    end
    repeat (4) tick(acc, cons, got, stl, rdy);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got %b expected 0", out_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc < 10) begin
        in_valid = 1'b1; a = 16'(cyc); b = 16'h1000; c_in = 1'b1; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      tick(acc, cons, got, stl, rdy);
      exp_v = (cyc >= 3 && cyc < 13);
      n_checks++;
      if (out_valid !== exp_v) begin
        n_fail++; $display("FAIL b2b_valid cyc %0d: got %b expected %b", cyc, out_valid, exp_v);
      end
      if (exp_v) begin
        ev = 16'h1001 + 16'(cyc - 3);
        n_checks++;
        if ({ovf, c_out, s} !== {2'b00, ev}) begin
          n_fail++; $display("FAIL b2b_data cyc %0d: got %h expected %h", cyc, {ovf, c_out, s}, {2'b00, ev});
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_stall();
    sent = 0; got_n = 0;
    for (int cyc = 0; cyc < 200 && got_n < 20; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 12);
      if (sent < 20) begin
        in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
        c_in = 1'($urandom); sub = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      tick(acc, cons, got, stl, rdy);
      if (acc) sent++;
      n_checks++;
      if (rdy !== !stl) begin
        n_fail++; $display("FAIL stall_in_ready cyc %0d: got %b expected %b", cyc, rdy, !stl);
      end
      if (stl) begin
        n_checks++;
        if ({out_valid, ovf, c_out, s} !== {1'b1, got}) begin
          n_fail++; $display("FAIL stall_hold cyc %0d: got %h expected %h", cyc, {out_valid, ovf, c_out, s}, {1'b1, got});
        end
      end
      if (cons) begin
        got_n++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stall_extra_result: got %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++; $display("FAIL stall_result %0d: got %h expected %h", got_n, got, e);
          end
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (got_n != 20 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL stall_count: got %0d results (%0d pending) expected 20 (0)", got_n, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    repeat (4) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); c_in = 1'b0; sub = 1'b0;
      tick(acc, cons, got, stl, rdy);
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL midflight_valid: got %b expected 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, ovf, c_out, s, in_ready} !== {19'h0, 1'b1}) begin
      n_fail++; $display("FAIL reset_async: got %h expected %h", {out_valid, ovf, c_out, s, in_ready}, {19'h0, 1'b1});
    end
    tick(acc, cons, got, stl, rdy);
    rst_n = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      tick(acc, cons, got, stl, rdy);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL no_stale cyc %0d: got %b expected 0", i, out_valid);
      end
    end
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321; c_in = 1'b0; sub = 1'b0;
    tick(acc, cons, got, stl, rdy);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick(acc, cons, got, stl, rdy);
      lat++;
    end
    n_checks++;
    if (lat != 4 || {ovf, c_out, s} !== {2'b00, 16'h5555}) begin
      n_fail++; $display("FAIL post_reset_result: got lat %0d data %h expected lat 4 data %h", lat, {ovf, c_out, s}, {2'b00, 16'h5555});
    end
    tick(acc, cons, got, stl, rdy);
    exp_q.delete();
  endtask

  task automatic test_random();
    sent = 0; got_n = 0;
    for (int cyc = 0; cyc < 60000 && got_n < 10000; cyc++) begin
      out_ready = ($urandom_range(3) != 32'd0);
      if (sent < 10000 && $urandom_range(3) != 32'd0) begin
        in_valid = 1'b1; a = pick(); b = pick(); c_in = 1'($urandom); sub = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      tick(acc, cons, got, stl, rdy);
      if (acc) sent++;
      if (cons) begin
        got_n++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL random_extra_result: got %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++; $display("FAIL random_result %0d: got %h expected %h", got_n, got, e);
          end
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (got_n != 10000 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL random_count: got %0d results (%0d pending) expected 10000 (0)", got_n, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per pipeline stage; WIDTH SHALL be a positive multiple of CHUNK, and STAGES = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand set on a, b, c_in and sub is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the operands, treated as unsigned or as two's complement.
REQ-008 The block SHALL have port c_in, input, 1 bit: carry-in, used only when sub=0.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 selects a+b+c_in, 1 selects a-b.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result on s, c_out and ovf is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream accepts the result.
REQ-012 The block SHALL have port s, output, WIDTH bits: the sum or difference.
REQ-013 The block SHALL have port c_out, output, 1 bit: carry-out of the MSB; for sub=1 it is the no-borrow flag.
REQ-014 The block SHALL have port ovf, output, 1 bit: signed two's-complement overflow.

Function
REQ-015 An operand set SHALL be accepted on a rising clk edge where in_valid=1 and in_ready=1.
REQ-016 For sub=1 the block SHALL use b' = ~b with carry-in forced to 1, ignoring c_in; for sub=0 it SHALL use b' = b with carry-in c_in.
REQ-017 Stage k (k = 0..STAGES-1) SHALL add bits [k*CHUNK +: CHUNK] of a and b' plus the carry registered by stage k-1, with stage 0 using the resolved carry-in.
REQ-018 Each stage SHALL register its chunk sum, its carry-out, a valid bit, and the not-yet-added upper chunks of a and b'; chunk sums already produced SHALL be carried forward so that results stay aligned.
REQ-019 The final stage registers SHALL drive s, c_out and out_valid directly, with no combinational path from any input to any output except in_ready.
REQ-020 The block SHALL compute ovf = carry into MSB XOR carry out of MSB, registered with the final stage.
REQ-021 Latency SHALL be exactly STAGES cycles from acceptance to out_valid=1 when no stall occurs.
REQ-022 With no stall, the block SHALL accept one operand set per cycle.
REQ-023 The pipeline SHALL stall whenever out_valid=1 and out_ready=0: no stage register changes, and in_ready = !(out_valid & !out_ready).
REQ-024 While stalled, s, c_out, ovf and out_valid SHALL hold their values.
REQ-025 Bubbles (stage valid=0) SHALL propagate normally; data registers of an invalid stage SHALL be treated as don't-care.
REQ-026 A result SHALL be consumed on an edge where out_valid=1 and out_ready=1, and on that same edge the next pipeline contents SHALL advance.
REQ-027 Results SHALL emerge in acceptance order; no result is ever dropped or duplicated.
REQ-028 For CHUNK = WIDTH the block SHALL degenerate to a one-stage registered adder with latency 1.
REQ-029 Arithmetic SHALL wrap modulo 2^WIDTH; the carry beyond the MSB appears only on c_out.

Reset
REQ-030 Asserting rst_n=0 SHALL, asynchronously, clear all stage valid bits, out_valid, s, c_out and ovf to 0.
REQ-031 While rst_n=0, in_ready SHALL be 1 and no input SHALL be accepted.
REQ-032 Any operands in flight when reset asserts mid-operation SHALL be discarded; after release no stale result SHALL appear.
REQ-033 The first acceptance SHALL occur on the first rising edge after rst_n deasserts.

Verification (WIDTH=16, CHUNK=4)
REQ-034 Accept a=0xFFFF, b=0x0001, c_in=0, sub=0 with out_ready=1 -> 4 cycles later out_valid=1, s=0x0000, c_out=1, ovf=0.
REQ-035 Accept a=0x7FFF, b=0x0001, sub=0 -> s=0x8000, c_out=0, ovf=1; then accept a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, c_out=0, ovf=0.
REQ-036 Drive back-to-back inputs i=0..9 as a=i, b=0x1000, c_in=1, sub=0 -> results 0x1001+i on consecutive cycles, in order, starting at cycle 4.
REQ-037 Hold out_ready=0 for 6 cycles during a stream -> in_ready=0 while out_valid=1, outputs hold, no result is lost, and the stream resumes in order when out_ready=1.
REQ-038 Assert rst_n=0 for one cycle with 3 operands in flight -> out_valid=0 immediately; after release no result appears until a new operand is accepted, 4 cycles later.
REQ-039 Apply 10^4 random operands with random in_valid and out_ready -> every result matches a reference model for s, c_out and ovf, in acceptance order.
